fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch queue between the program counter / instruction memory stage and the decode stage. Each cycle it captures the fetched instruction and its PC into a small circular buffer, then presents the oldest entry to decode with a valid/ready handshake. It back-pressures the PC through `FetchReady`, so the PC holds while decode stalls. It also provides a single-cycle flush for taken branches and jumps.

## Interface

Parameters:
- `DEPTH`, 2 — number of queue entries; power of two, at least 2.
- `PC_LIMIT`, 127 — highest legal byte address; a sequential PC above this wraps to 0.

Ports:
- `Clk`  in  1  — clock; all state updates on the rising edge.
- `Reset`  in  1  — asynchronous, active-low reset.
- `FetchPC`  in  32  — byte address of the instruction being offered (the PC register output).
- `FetchInstruction`  in  32  — instruction word read at `FetchPC`.
- `FetchValid`  in  1  — offered fetch entry is valid.
- `FetchReady`  out  1  — queue accepts an entry this cycle; when 0, the PC must hold its value.
- `Flush`  in  1  — discard all queued entries and this cycle's push and pop.
- `DecodeReady`  in  1  — decode consumes the head entry this cycle.
- `DecodeValid`  out  1  — head entry is valid.
- `DecodeInstruction`  out  32  — head instruction; 0x00000000 (NOP) when empty.
- `DecodePC`  out  32  — head PC; 0 when empty.
- `DecodePCPlus4`  out  32  — head PC + 4, wrapped to 0 if above `PC_LIMIT`; 0 when empty.
- `Count`  out  clog2(DEPTH+1)  — number of occupied entries.

## Operation

Storage:
- `DEPTH` entries, each holding {PC, instruction}.
- Read pointer and write pointer, each log2(DEPTH) bits, wrapping modulo `DEPTH`.
- `Count` register, range 0..DEPTH.

Handshake signals:
- push = FetchValid & FetchReady & ~Flush
- pop = DecodeValid & DecodeReady & ~Flush
- FetchReady = Reset & (Count != DEPTH). It is a function of `Count` only and never depends on `DecodeReady`, so there is no combinational path from decode to fetch.
- DecodeValid = (Count != 0).

Update rules:
- Push only: write the entry at the write pointer, advance the write pointer, Count+1.
- Pop only: advance the read pointer, Count−1.
- Push and pop together (legal whenever 0 < Count < DEPTH): both pointers advance, Count is unchanged.
- Full: FetchReady=0, so no push is possible even if a pop occurs that cycle. No bypass.
- Empty: no fall-through. An entry pushed at edge N first appears on the decode outputs after edge N.

Flush:
- At the next edge, both pointers go to 0 and Count goes to 0.
- Flush has priority over push and pop; that cycle's fetch entry is dropped and is not counted as consumed.

Decode outputs:
- Driven combinationally from the head entry, gated to 0 when Count=0.

DecodePCPlus4 arithmetic:
- Compute the 32-bit sum head PC + 4.
- If the sum is greater than `PC_LIMIT`, output 0; otherwise output the sum.
- Example: PC 124 gives 0; PC 120 gives 124.

Reset (Reset=0, asynchronous):
- Pointers=0, Count=0.
- DecodeValid=0; DecodeInstruction, DecodePC and DecodePCPlus4 = 0.
- FetchReady=0.
- Stored entries need not be cleared.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- After Reset deasserts, FetchReady=1 in the same cycle; the first push can occur at the next edge.

## Timing

- Latency from push to DecodeValid: 1 edge.
- Steady-state throughput: 1 entry per cycle, provided DecodeReady is held high and Count stays below DEPTH.
- Count, pointers and stored entries are registered.
- FetchReady and the Decode outputs are combinational from registered state (plus Reset for FetchReady).
- Flush asserted at edge N: at N+1, DecodeValid=0 and FetchReady=1.

## Test plan

- **Reset:** hold Reset=0 with FetchValid=1 and push data present → DecodeValid=0, FetchReady=0, Count=0, all Decode outputs 0. Release Reset → FetchReady=1.
- **Streaming:** push PCs 0, 4, 8 with DecodeReady=1 every cycle → each instruction appears on decode one edge after its push, in order, with DecodePCPlus4 = 4, 8, 12 and Count staying at 1.
- **Fill and back-pressure:** DecodeReady=0, push PCs 0 and 4 → Count=2 and FetchReady=0. A third offer (PC 8) is not accepted. Raise DecodeReady → PC 0 then PC 4 are popped, and PC 8 is accepted only once FetchReady=1.
- **Flush priority:** with the queue holding 2 entries, assert Flush together with FetchValid=1 and DecodeReady=1 → next edge gives Count=0 and DecodeValid=0. The offered entry is never seen on decode.
- **Wrap:** head PC=124 → DecodePCPlus4=0. Head PC=120 → 124. Pointer wrap-around after more than DEPTH pushes preserves FIFO order.
- **Mid-operation reset:** assert Reset between clock edges with Count=2 → DecodeValid drops to 0 without a clock edge. After release, Count=0.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer of {PC, instruction} between fetch and decode.
// Latency: an entry pushed at edge N is visible to decode after edge N (no fall-through, no bypass).
// Backpressure: FetchReady depends only on occupancy (full -> 0); Flush drops all entries and this cycle's push/pop.
module fetch_queue #(
    parameter int DEPTH    = 2,
    parameter int PC_LIMIT = 127
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic [31:0]                  FetchPC,
    input  logic [31:0]                  FetchInstruction,
    input  logic                         FetchValid,
    output logic                         FetchReady,
    input  logic                         Flush,
    input  logic                         DecodeReady,
    output logic                         DecodeValid,
    output logic [31:0]                  DecodeInstruction,
    output logic [31:0]                  DecodePC,
    output logic [31:0]                  DecodePCPlus4,
    output logic [$clog2(DEPTH+1)-1:0]   Count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [31:0]   PC_MAX     = 32'(PC_LIMIT);

    // Entry storage is not reset; occupancy alone decides what is valid.
    logic [31:0]   r_pc_mem    [DEPTH];
    logic [31:0]   r_instr_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_head_pc;
    logic [31:0]   w_head_instr;
    logic [31:0]   w_pc_sum;

    assign w_full  = (r_count == FULL_COUNT);
    assign w_empty = (r_count == '0);

    // Ready is a pure function of occupancy, so decode stalls never reach fetch combinationally.
    assign FetchReady  = Reset & ~w_full;
    assign DecodeValid = ~w_empty;

    assign w_push = FetchValid & FetchReady & ~Flush;
    assign w_pop  = DecodeValid & DecodeReady & ~Flush;

    assign w_head_pc    = r_pc_mem[r_rd_ptr];
    assign w_head_instr = r_instr_mem[r_rd_ptr];
    assign w_pc_sum     = w_head_pc + 32'd4;

    // Head presentation, forced to zero (NOP / PC 0) while the queue is empty.
    always_comb begin
        DecodeInstruction = 32'd0;
        DecodePC          = 32'd0;
        DecodePCPlus4     = 32'd0;
        if (!w_empty) begin
            DecodeInstruction = w_head_instr;
            DecodePC          = w_head_pc;
            DecodePCPlus4     = (w_pc_sum > PC_MAX) ? 32'd0 : w_pc_sum;
        end
    end

    // Write the offered entry into the slot at the write pointer on an accepted push.
    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= FetchPC;
            r_instr_mem[r_wr_ptr] <= FetchInstruction;
        end
    end

    // Pointer and occupancy update; flush outranks push and pop.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (Flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign Count = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: scoreboard of accepted {PC, instruction} entries.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Directed reset/stream/fill/flush/mid-reset phases plus a random stream that wraps PC and pointers.
module tb_fetch_queue;

    localparam int DEPTH    = 2;
    localparam int PC_LIMIT = 127;
    localparam int CW       = $clog2(DEPTH + 1);

    logic          Clk;
    logic          Reset;
    logic [31:0]   FetchPC;
    logic [31:0]   FetchInstruction;
    logic          FetchValid;
    logic          FetchReady;
    logic          Flush;
    logic          DecodeReady;
    logic          DecodeValid;
    logic [31:0]   DecodeInstruction;
    logic [31:0]   DecodePC;
    logic [31:0]   DecodePCPlus4;
    logic [CW-1:0] Count;

    int n_cmp = 0;
    int n_err = 0;

    // Scoreboard entries: {pc, instruction}
    logic [63:0] sb_q[$];

    fetch_queue #(.DEPTH(DEPTH), .PC_LIMIT(PC_LIMIT)) dut (
        .Clk               (Clk),
        .Reset             (Reset),
        .FetchPC           (FetchPC),
        .FetchInstruction  (FetchInstruction),
        .FetchValid        (FetchValid),
        .FetchReady        (FetchReady),
        .Flush             (Flush),
        .DecodeReady       (DecodeReady),
        .DecodeValid       (DecodeValid),
        .DecodeInstruction (DecodeInstruction),
        .DecodePC          (DecodePC),
        .DecodePCPlus4     (DecodePCPlus4),
        .Count             (Count)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        logic [31:0] s;
        s = pc + 32'd4;
        return (s > 32'(PC_LIMIT)) ? 32'd0 : s;
    endfunction

    // One clock cycle: drive, sample on falling edge, advance the model, move past the rising edge.
    task automatic step(input logic fv, input logic [31:0] pc, input logic [31:0] instr,
                        input logic dr, input logic fl, output logic acc);
        logic        exp_rdy;
        logic [63:0] head;
        FetchValid       = fv;
        FetchPC          = pc;
        FetchInstruction = instr;
        DecodeReady      = dr;
        Flush            = fl;
        @(negedge Clk);
        exp_rdy = (sb_q.size() != DEPTH);
        check("fetch_ready", 32'(FetchReady), exp_rdy ? 32'd1 : 32'd0);
        check("decode_valid", 32'(DecodeValid), (sb_q.size() != 0) ? 32'd1 : 32'd0);
        check("count", 32'(Count), 32'(sb_q.size()));
        if (sb_q.size() != 0) begin
            head = sb_q[0];
            check("head_instr", DecodeInstruction, head[31:0]);
            check("head_pc", DecodePC, head[63:32]);
            check("head_pc4", DecodePCPlus4, pc_plus4(head[63:32]));
        end else begin
            check("empty_instr", DecodeInstruction, 32'd0);
            check("empty_pc", DecodePC, 32'd0);
            check("empty_pc4", DecodePCPlus4, 32'd0);
        end
        acc = fv & exp_rdy & ~fl;
        if (fl) begin
            sb_q.delete();
        end else begin
            if (dr && sb_q.size() != 0) void'(sb_q.pop_front());
            if (acc) sb_q.push_back({pc, instr});
        end
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic        acc;
        logic [31:0] pc;
        logic [15:0] seq;

        // Reset held with a valid offer present.
        Reset            = 1'b0;
        FetchValid       = 1'b1;
        FetchPC          = 32'h40;
        FetchInstruction = 32'hDEADBEEF;
        DecodeReady      = 1'b1;
        Flush            = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_valid", 32'(DecodeValid), 32'd0);
        check("rst_ready", 32'(FetchReady), 32'd0);
        check("rst_count", 32'(Count), 32'd0);
        check("rst_instr", DecodeInstruction, 32'd0);
        check("rst_pc", DecodePC, 32'd0);
        check("rst_pc4", DecodePCPlus4, 32'd0);
        Reset = 1'b1;
        #1;
        check("rel_ready", 32'(FetchReady), 32'd1);

        // Streaming with decode always ready.
        step(1'b1, 32'd0, 32'h1111_0000, 1'b1, 1'b0, acc);
        step(1'b1, 32'd4, 32'h1111_0004, 1'b1, 1'b0, acc);
        step(1'b1, 32'd8, 32'h1111_0008, 1'b1, 1'b0, acc);
        step(1'b0, 32'd0, 32'h0,         1'b1, 1'b0, acc);

        // Fill, back-pressure, then drain while PC 8 is held on the fetch side.
        step(1'b1, 32'd0, 32'h2222_0000, 1'b0, 1'b0, acc);
        step(1'b1, 32'd4, 32'h2222_0004, 1'b0, 1'b0, acc);
        step(1'b1, 32'd8, 32'h2222_0008, 1'b0, 1'b0, acc);
        check("full_reject", 32'(acc), 32'd0);
        step(1'b1, 32'd8, 32'h2222_0008, 1'b1, 1'b0, acc);
        check("full_pop_reject", 32'(acc), 32'd0);
        step(1'b1, 32'd8, 32'h2222_0008, 1'b1, 1'b0, acc);
        check("reaccept", 32'(acc), 32'd1);
        step(1'b0, 32'd0, 32'h0,         1'b1, 1'b0, acc);
        step(1'b0, 32'd0, 32'h0,         1'b1, 1'b0, acc);

        // Flush with two entries queued, a valid offer and decode ready.
        step(1'b1, 32'd120, 32'h3333_0078, 1'b0, 1'b0, acc);
        step(1'b1, 32'd124, 32'h3333_007C, 1'b0, 1'b0, acc);
        step(1'b1, 32'h50,  32'hBADC0DE0,  1'b1, 1'b1, acc);
        check("flush_drop", 32'(acc), 32'd0);
        step(1'b0, 32'd0, 32'h0, 1'b1, 1'b0, acc);

        // Heads at 120 and 124 to exercise the PC+4 wrap.
        step(1'b1, 32'd120, 32'h4444_0078, 1'b0, 1'b0, acc);
        step(1'b1, 32'd124, 32'h4444_007C, 1'b0, 1'b0, acc);
        step(1'b0, 32'd0,   32'h0,         1'b1, 1'b0, acc);
        check("wrap_pc124", DecodePCPlus4, 32'd0);
        step(1'b0, 32'd0,   32'h0,         1'b1, 1'b0, acc);

        // Random stream: PC advances only when accepted, wrapping past the limit.
        pc  = 32'd100;
        seq = 16'd0;
        for (int i = 0; i < 40; i++) begin
            step($urandom_range(0, 3) != 0, pc, {seq, 16'hC0DE},
                 $urandom_range(0, 2) != 0, 1'b0, acc);
            if (acc) begin
                pc  = pc_plus4(pc);
                seq = seq + 16'd1;
            end
        end
        step(1'b0, 32'd0, 32'h0, 1'b1, 1'b0, acc);
        step(1'b0, 32'd0, 32'h0, 1'b1, 1'b0, acc);

        // Mid-operation reset between edges with two entries held.
        step(1'b1, 32'd16, 32'h5555_0010, 1'b0, 1'b0, acc);
        step(1'b1, 32'd20, 32'h5555_0014, 1'b0, 1'b0, acc);
        #2;
        Reset = 1'b0;
        #1;
        check("midrst_valid", 32'(DecodeValid), 32'd0);
        check("midrst_count", 32'(Count), 32'd0);
        check("midrst_ready", 32'(FetchReady), 32'd0);
        check("midrst_pc", DecodePC, 32'd0);
        sb_q.delete();
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        #1;
        check("midrst_rel_ready", 32'(FetchReady), 32'd1);
        check("midrst_rel_count", 32'(Count), 32'd0);
        step(1'b1, 32'd24, 32'h6666_0018, 1'b1, 1'b0, acc);
        step(1'b0, 32'd0,  32'h0,         1'b1, 1'b0, acc);
        step(1'b0, 32'd0,  32'h0,         1'b1, 1'b0, acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
